// File: rtl/cell_pipe_array_if.sv
// cell_pipe_array_if: input/output beat handshake bundle for cell_pipe_array
//   master: drives in_* operands plus out_ready (upstream/downstream side)
//   slave : drives in_ready and out_* results (the processor)
interface cell_pipe_array_if #(
  parameter int LANES = 4,
  parameter int CHAN_W = 8
);
  localparam int CELL_W = 3 * CHAN_W;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*CELL_W-1:0] in_cellA;
  logic [LANES*CELL_W-1:0] in_cellB;
  logic [CHAN_W-1:0]       in_user;
  logic [2:0]              in_opcode;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*CELL_W-1:0] out_cell;
  logic                    out_last;
  modport master (
    output in_valid, in_cellA, in_cellB, in_user, in_opcode, in_last, out_ready,
    input  in_ready, out_valid, out_cell, out_last
  );
  modport slave (
    input  in_valid, in_cellA, in_cellB, in_user, in_opcode, in_last, out_ready,
    output in_ready, out_valid, out_cell, out_last
  );
endinterface

// File: rtl/cell_pipe_array.sv
// cell_pipe_array: two-stage LANES-wide RGB cell processor with valid/ready handshakes
//   clk, rst          : single clock, synchronous active-high reset
//   bus (slave)       : in_* operand beat in, out_* result beat out
//   sat_clr, sat_count: clipped-channel counter, present only with CELL_PIPE_SATCNT_EN
module cell_pipe_array #(
  parameter int LANES = 4,
  parameter int CHAN_W = 8
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CELL_PIPE_SATCNT_EN
  input  logic        sat_clr,
  output logic [31:0] sat_count,
`endif
  cell_pipe_array_if.slave bus
);
  localparam int CELL_W = 3 * CHAN_W;
  localparam int N = 3 * LANES;
  localparam logic [CHAN_W-1:0] MAX = '1;
  logic                    w_adv;
  logic                    r_s1_valid;
  logic [LANES*CELL_W-1:0] r_a;
  logic [LANES*CELL_W-1:0] r_b;
  logic [CHAN_W-1:0]       r_user;
  logic [2:0]              r_op;
  logic                    r_s1_last;
  logic [LANES*CELL_W-1:0] w_res;
  function automatic logic [CHAN_W-1:0] op_ch(input logic [2:0] op,
                                              input logic [CHAN_W-1:0] a, b, u);
    logic [CHAN_W:0] s_ab, s_au, d_ab, d_au;
    s_ab = {1'b0, a} + {1'b0, b};
    s_au = {1'b0, a} + {1'b0, u};
    d_ab = {1'b0, a} - {1'b0, b};
    d_au = {1'b0, a} - {1'b0, u};
    // the extra MSB of each intermediate is the carry/borrow that triggers clamping
    case (op)
      3'd0:    op_ch = a;
      3'd1:    op_ch = s_ab[CHAN_W] ? MAX : s_ab[CHAN_W-1:0];
      3'd2:    op_ch = d_ab[CHAN_W] ? '0 : d_ab[CHAN_W-1:0];
      3'd3:    op_ch = s_au[CHAN_W] ? MAX : s_au[CHAN_W-1:0];
      3'd4:    op_ch = d_au[CHAN_W] ? '0 : d_au[CHAN_W-1:0];
      3'd5:    op_ch = CHAN_W'((s_ab + 1'b1) >> 1);
      3'd6:    op_ch = ~a;
      default: op_ch = (a >= u) ? MAX : '0;
    endcase
  endfunction
  assign w_adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = rst || w_adv;
  always_comb begin
    w_res = '0;
    for (int i = 0; i < N; i++)
      w_res[i*CHAN_W +: CHAN_W] = op_ch(r_op, r_a[i*CHAN_W +: CHAN_W], r_b[i*CHAN_W +: CHAN_W], r_user);
  end
`ifdef CELL_PIPE_SATCNT_EN
  localparam int CNT_W = $clog2(N + 1);
  logic [CNT_W-1:0] w_clip_n;
  logic [CNT_W-1:0] r_clip_n;
  function automatic logic clip_ch(input logic [2:0] op, input logic [CHAN_W-1:0] a, b, u);
    clip_ch = (op == 3'd1 && ({1'b0, a} + {1'b0, b}) > {1'b0, MAX}) ||
              (op == 3'd2 && a < b) ||
              (op == 3'd3 && ({1'b0, a} + {1'b0, u}) > {1'b0, MAX}) ||
              (op == 3'd4 && a < u);
  endfunction
  always_comb begin
    w_clip_n = '0;
    for (int i = 0; i < N; i++)
      w_clip_n = w_clip_n + CNT_W'(clip_ch(r_op, r_a[i*CHAN_W +: CHAN_W], r_b[i*CHAN_W +: CHAN_W], r_user));
  end
  // clip count travels with the result so it is credited on that beat's output transfer
  always_ff @(posedge clk) begin
    if (rst) r_clip_n <= '0;
    else if (w_adv) r_clip_n <= r_s1_valid ? w_clip_n : '0;
  end
  always_ff @(posedge clk) begin
    if (rst || sat_clr) sat_count <= '0;
    else if (bus.out_valid && bus.out_ready)
      sat_count <= (sat_count > 32'hFFFF_FFFF - 32'(r_clip_n)) ? 32'hFFFF_FFFF : sat_count + 32'(r_clip_n);
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_user        <= '0;
      r_op          <= '0;
      r_s1_last     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_cell  <= '0;
      bus.out_last  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid    <= bus.in_valid;
      r_a           <= bus.in_cellA;
      r_b           <= bus.in_cellB;
      r_user        <= bus.in_user;
      r_op          <= bus.in_opcode;
      r_s1_last     <= bus.in_valid && bus.in_last;
      bus.out_valid <= r_s1_valid;
      bus.out_cell  <= w_res;
      bus.out_last  <= r_s1_last;
    end
  end
endmodule

// File: tb/tb_cell_pipe_array.sv
// tb_cell_pipe_array: vector table, stall/reset sequences and random stream against a reference model
module tb_cell_pipe_array;
  localparam int LANES = 4, CHAN_W = 8, CW = 24, W = LANES * CW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cell_pipe_array_if #(.LANES(LANES), .CHAN_W(CHAN_W)) bus ();
`ifdef CELL_PIPE_SATCNT_EN
  logic        sat_clr = 1'b0;
  logic [31:0] sat_count;
`endif
  cell_pipe_array #(.LANES(LANES), .CHAN_W(CHAN_W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef CELL_PIPE_SATCNT_EN
    .sat_clr(sat_clr),
    .sat_count(sat_count),
`endif
    .bus(bus)
  );
  typedef struct {
    logic [2:0]    op;
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic [7:0]    u;
    logic [CW-1:0] res;
  } vec_t;
  vec_t       tv[13];
  int         n_tests = 0, n_fail = 0;
  int         n_out, n_last, k;
  bit         mon = 0, acc, stalled;
  logic [W:0] sb[$];
  logic [W:0] held;
  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic logic [CW-1:0] ref_cell(input logic [2:0] op, input logic [CW-1:0] a, b,
                                             input logic [7:0] u);
    logic [CW-1:0] r;
    for (int c = 0; c < 3; c++) begin
      int x, y, z, v;
      x = a[8*c +: 8];
      y = b[8*c +: 8];
      z = u;
      case (op)
        3'd0:    v = x;
        3'd1:    v = (x + y > 255) ? 255 : x + y;
        3'd2:    v = (x < y) ? 0 : x - y;
        3'd3:    v = (x + z > 255) ? 255 : x + z;
        3'd4:    v = (x < z) ? 0 : x - z;
        3'd5:    v = (x + y + 1) / 2;
        3'd6:    v = 255 - x;
        default: v = (x >= z) ? 255 : 0;
      endcase
      r[8*c +: 8] = v[7:0];
    end
    return r;
  endfunction
  function automatic logic [W-1:0] ref_beat(input logic [2:0] op, input logic [W-1:0] a, b,
                                            input logic [7:0] u);
    logic [W-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*CW +: CW] = ref_cell(op, a[l*CW +: CW], b[l*CW +: CW], u);
    return r;
  endfunction
  task automatic tick();
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (mon) begin
      if (acc) sb.push_back({bus.in_last, ref_beat(bus.in_opcode, bus.in_cellA, bus.in_cellB, bus.in_user)});
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (bus.out_last) n_last++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %h expected no beat", {bus.out_last, bus.out_cell});
        end else check("stream", {bus.out_last, bus.out_cell}, sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rand_beat();
    bus.in_cellA  = {$urandom, $urandom, $urandom};
    bus.in_cellB  = {$urandom, $urandom, $urandom};
    bus.in_user   = 8'($urandom);
    bus.in_opcode = 3'($urandom);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{3'd1, 24'hC80A00, 24'h641400, 8'h00, 24'hFF1E00};
    tv[1]  = '{3'd5, 24'h0300FF, 24'h0400FE, 8'h00, 24'h0400FF};
    tv[2]  = '{3'd7, 24'h7F80FF, 24'h000000, 8'h80, 24'h00FFFF};
    tv[3]  = '{3'd0, 24'h123456, 24'hABCDEF, 8'h00, 24'h123456};
    tv[4]  = '{3'd1, 24'hFFFE01, 24'h0001FE, 8'h00, 24'hFFFFFF};
    tv[5]  = '{3'd2, 24'hC80A05, 24'h640305, 8'h00, 24'h640700};
    tv[6]  = '{3'd2, 24'h0A0500, 24'h140501, 8'h00, 24'h000000};
    tv[7]  = '{3'd3, 24'hF0EF00, 24'h000000, 8'h10, 24'hFFFF10};
    tv[8]  = '{3'd4, 24'h100FC8, 24'h000000, 8'h10, 24'h0000B8};
    tv[9]  = '{3'd5, 24'hFF0001, 24'hFF0000, 8'h00, 24'hFF0001};
    tv[10] = '{3'd6, 24'h00FF5A, 24'h000000, 8'h00, 24'hFF00A5};
    tv[11] = '{3'd7, 24'h000000, 24'h000000, 8'h00, 24'hFFFFFF};
    tv[12] = '{3'd7, 24'hFEFF00, 24'h000000, 8'hFF, 24'h00FF00};
    bus.in_valid = 0; bus.in_last = 0; bus.out_ready = 0;
    bus.in_cellA = '0; bus.in_cellB = '0; bus.in_user = '0; bus.in_opcode = '0;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_cell", bus.out_cell, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 0;
    bus.out_ready = 1;
    foreach (tv[i]) begin
      rand_beat();
      bus.in_cellA[CW-1:0] = tv[i].a;
      bus.in_cellB[CW-1:0] = tv[i].b;
      bus.in_user = tv[i].u;
      bus.in_opcode = tv[i].op;
      bus.in_valid = 1;
      tick();
      bus.in_valid = 0;
      tick();
      check("vec_valid", bus.out_valid, 1);
      check("vec_lane0", bus.out_cell[CW-1:0], tv[i].res);
      check("vec_all", bus.out_cell, ref_beat(bus.in_opcode, bus.in_cellA, bus.in_cellB, bus.in_user));
      tick();
      check("vec_drain", bus.out_valid, 0);
    end
    mon = 1; sb.delete(); n_out = 0; n_last = 0; k = 0; stalled = 0;
    for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      rand_beat();
      bus.in_opcode = 3'd6;
      bus.in_valid = (k < 8);
      bus.in_last = (k == 7);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        check("stall_in_ready", bus.in_ready, 0);
        if (stalled) check("stall_hold", {bus.out_last, bus.out_cell}, held);
        held = {bus.out_last, bus.out_cell};
        stalled = 1;
      end else stalled = 0;
      tick();
      if (acc) k++;
    end
    bus.in_valid = 0; bus.in_last = 0;
    check("stall_count", n_out, 8);
    check("stall_last", n_last, 1);
    check("stall_sb", sb.size(), 0);
    mon = 0; bus.out_ready = 0;
    rand_beat();
    bus.in_valid = 1;
    tick();
    rand_beat();
    tick();
    bus.in_valid = 0;
    check("rst_inflight", bus.out_valid, 1);
    rst = 1;
    #1;
    check("rst_in_ready_stalled", bus.in_ready, 1);
    tick();
    rst = 0;
    check("rst_flush", bus.out_valid, 0);
    mon = 1; sb.delete(); n_out = 0;
    bus.out_ready = 1;
    rand_beat();
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    repeat (6) tick();
    check("rst_single_out", n_out, 1);
    check("rst_sb", sb.size(), 0);
    sb.delete(); n_out = 0;
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      if ($urandom_range(0, 3) == 0) bus.in_user = $urandom_range(0, 1) ? 8'hFF : 8'h00;
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.in_last = $urandom_range(0, 7) == 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    bus.in_valid = 0; bus.out_ready = 1;
    repeat (4) tick();
    check("rand_drain", sb.size(), 0);
    check("rand_some", n_out != 0, 1);
`ifdef CELL_PIPE_SATCNT_EN
    mon = 0;
    sat_clr = 1;
    tick();
    sat_clr = 0;
    check("sat_clr_idle", sat_count, 0);
    bus.in_cellA = '0; bus.in_cellB = '0; bus.in_opcode = 3'd1; bus.in_last = 0;
    bus.in_cellA[CW-1:0] = 24'hC8C800;
    bus.in_cellB[CW-1:0] = 24'h646400;
    bus.in_valid = 1;
    repeat (3) tick();
    bus.in_valid = 0;
    repeat (3) tick();
    check("sat_count6", sat_count, 6);
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    tick();
    sat_clr = 1;
    tick();
    sat_clr = 0;
    check("sat_clr_wins", sat_count, 0);
    tick();
    check("sat_stay0", sat_count, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
